qcw_ramp_ctrl: RTL and testbench

Burst sequencer that drives the QCW PLL gate-drive block from the control side. It accepts a fire request, issues the PLL start pulse, and loads the cycle limit. During the burst it ramps the PLL phase shift once per drive cycle, then enforces an off-time before allowing the next burst. It also owns abort, watchdog and fault reporting, and sits between the host/interrupter logic and the PLL.

---
 rtl/qcw_pkg.sv | 28 ++
 rtl/qcw_phase_ramp.sv | 54 +++++
 rtl/qcw_ramp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_qcw_ramp_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcw_pkg.sv
// Shared types and constants for the QCW burst ramp controller.
package qcw_pkg;

  localparam int ACC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_STOP    = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_PLL  = 2'b01;
  localparam logic [1:0] FC_ARM  = 2'b10;
  localparam logic [1:0] FC_WDOG = 2'b11;

  // Burst settings captured when fire is accepted
  typedef struct packed {
    logic [7:0]  phase_start;
    logic [7:0]  phase_end;
    logic [15:0] phase_step;
    logic [23:0] holdoff;
  } cfg_t;

endpackage

// File: rtl/qcw_phase_ramp.sv
// 8.8 phase accumulator that steps toward a target and clamps on arrival.
// The target port stands for the ramp end value ("end" is a reserved word).
module qcw_phase_ramp
  import qcw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step_en,
  input  logic [7:0]  start,
  input  logic [7:0]  target,
  input  logic [15:0] step,
  output logic [7:0]  phase
);

  logic [ACC_W-1:0] acc;
  logic             up;

  // One step toward the target; the 17th bit catches both overflow and underflow
  function automatic logic [ACC_W-1:0] next_acc(input logic [ACC_W-1:0] cur,
                                                input logic [15:0]      stp,
                                                input logic [7:0]       tgt,
                                                input logic             dir_up);
    logic [ACC_W:0] wide;
    logic [ACC_W:0] goal;
    goal = {1'b0, tgt, 8'h00};
    if (dir_up) begin
      wide = {1'b0, cur} + {1'b0, stp};
      if (wide > goal) next_acc = goal[ACC_W-1:0];
      else             next_acc = wide[ACC_W-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, stp};
      if (wide[ACC_W] || (wide < goal)) next_acc = goal[ACC_W-1:0];
      else                              next_acc = wide[ACC_W-1:0];
    end
    return next_acc;
  endfunction

  assign up = (target >= start);

  // Accumulator register: load has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {start, 8'h00};
    end else if (step_en) begin
      acc <= next_acc(acc, step, target, up);
    end
  end

  assign phase = acc[ACC_W-1:ACC_W-8];

endmodule

// File: rtl/qcw_ramp_ctrl.sv
// QCW burst sequencer: start, phase ramp, abort/halt, holdoff and fault reporting.
// Define QCW_RAMP_WDOG_EN to build in the RUN-state watchdog.
module qcw_ramp_ctrl
  import qcw_pkg::*;
#(
  parameter int unsigned ARM_TIMEOUT = 64,
  parameter int unsigned WDOG_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic        abort,
  input  logic        clear_fault,
  input  logic [15:0] ramp_cycles,
  input  logic [7:0]  phase_start,
  input  logic [7:0]  phase_end,
  input  logic [15:0] phase_step,
  input  logic [23:0] holdoff,
  input  logic        pll_cycle_finished,
  input  logic        pll_done,
  input  logic        pll_fault,
  output logic        pll_start,
  output logic        pll_halt,
  output logic [7:0]  phase_shift,
  output logic [15:0] cycle_limit,
  output logic        busy,
  output logic        burst_done,
  output logic        fault_flag,
  output logic [1:0]  fault_code
);

  localparam int unsigned      ARM_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

  state_t           state, state_nx;
  cfg_t             cfg;
  logic [ARM_W-1:0] arm_cnt;
  logic [23:0]      ho_cnt;
  logic             abort_pend, stop_wdog;
  logic             cf_q, cf_q2, done_q;
  logic             cf_rise, done_rise, wdog_expire;
  logic             fire_load, to_fault, ramp_load, ramp_step;
  logic [7:0]       ramp_start;
  logic             burst_done_nx;
  logic [1:0]       fault_code_nx;

  assign fire_load = (state == ST_IDLE) && fire;
  assign to_fault  = (state_nx == ST_FAULT) && (state != ST_FAULT);
  assign cf_rise   = cf_q & ~cf_q2;
  assign done_rise = pll_done & ~done_q;
  assign ramp_step = (state == ST_RUN) && cf_rise;
  // Entering FAULT reloads the accumulator with zero so the PLL sees no phase shift
  assign ramp_load  = fire_load | to_fault;
  assign ramp_start = to_fault ? 8'h00 : ((state == ST_IDLE) ? phase_start : cfg.phase_start);

`ifdef QCW_RAMP_WDOG_EN
  localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wdog_cnt;

  // Watchdog counts RUN cycles; it is held at zero everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wdog_cnt <= '0;
    else if (state != ST_RUN)    wdog_cnt <= '0;
    else if (wdog_cnt != WD_LAST) wdog_cnt <= wdog_cnt + WD_W'(1);
  end

  assign wdog_expire = (state == ST_RUN) && (wdog_cnt == WD_LAST);
`else
  assign wdog_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state, completion pulse and fault code selection
  always_comb begin
    state_nx      = state;
    burst_done_nx = 1'b0;
    fault_code_nx = fault_code;
    case (state)
      ST_IDLE: begin
        if (fire) state_nx = ST_ARM;
        else      state_nx = ST_IDLE;
      end
      ST_ARM: begin
        if ((arm_cnt != '0) && !pll_done && !pll_fault) begin
          state_nx = ST_RUN;
        end else if (arm_cnt == ARM_LAST) begin
          state_nx      = ST_FAULT;
          fault_code_nx = FC_ARM;
        end else begin
          state_nx = ST_ARM;
        end
      end
      ST_RUN: begin
        if (pll_fault) begin
          state_nx      = ST_FAULT;
          fault_code_nx = FC_PLL;
        end else if (done_rise) begin
          state_nx      = ST_HOLDOFF;
          burst_done_nx = 1'b1;
        end else if (abort_pend || wdog_expire) begin
          state_nx = ST_STOP;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_STOP: begin
        // A fault here is the PLL acknowledging the halt, not an error on abort
        if (pll_fault || pll_done) begin
          if (stop_wdog) begin
            state_nx      = ST_FAULT;
            fault_code_nx = FC_WDOG;
          end else begin
            state_nx      = ST_HOLDOFF;
            burst_done_nx = 1'b1;
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      ST_HOLDOFF: begin
        if (ho_cnt == 24'd0) state_nx = ST_IDLE;
        else                 state_nx = ST_HOLDOFF;
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_nx      = ST_IDLE;
          fault_code_nx = FC_NONE;
        end else begin
          state_nx = ST_FAULT;
        end
      end
      default: begin
        state_nx      = ST_IDLE;
        fault_code_nx = FC_NONE;
      end
    endcase
  end

  // Burst configuration, edge history and per-state counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg        <= '0;
      cf_q       <= 1'b0;
      cf_q2      <= 1'b0;
      done_q     <= 1'b0;
      arm_cnt    <= '0;
      ho_cnt     <= 24'd0;
      abort_pend <= 1'b0;
      stop_wdog  <= 1'b0;
    end else begin
      cf_q   <= pll_cycle_finished;
      cf_q2  <= cf_q;
      done_q <= pll_done;
      if (fire_load) begin
        cfg <= '{phase_start: phase_start, phase_end: phase_end,
                 phase_step: phase_step, holdoff: holdoff};
      end
      if (state != ST_ARM)          arm_cnt <= '0;
      else if (arm_cnt != ARM_LAST) arm_cnt <= arm_cnt + ARM_W'(1);
      if (state != ST_HOLDOFF)      ho_cnt <= cfg.holdoff;
      else if (ho_cnt != 24'd0)     ho_cnt <= ho_cnt - 24'd1;
      if ((state == ST_ARM) || (state == ST_RUN)) abort_pend <= abort_pend | abort;
      else if (state == ST_IDLE)                  abort_pend <= 1'b0;
      if ((state == ST_RUN) && (state_nx == ST_STOP)) stop_wdog <= wdog_expire & ~abort_pend;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_start   <= 1'b0;
      pll_halt    <= 1'b0;
      cycle_limit <= 16'd0;
      busy        <= 1'b0;
      burst_done  <= 1'b0;
      fault_flag  <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      pll_start  <= fire_load;
      pll_halt   <= (state_nx == ST_STOP);
      busy       <= (state_nx != ST_IDLE);
      burst_done <= burst_done_nx;
      fault_flag <= (state_nx == ST_FAULT);
      fault_code <= fault_code_nx;
      if (fire_load) cycle_limit <= ramp_cycles;
    end
  end

  qcw_phase_ramp u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ramp_load),
    .step_en (ramp_step),
    .start   (ramp_start),
    .target  (cfg.phase_end),
    .step    (cfg.phase_step),
    .phase   (phase_shift)
  );

endmodule

// File: tb/tb_qcw_ramp_ctrl.sv
// Self-checking bench for qcw_ramp_ctrl: directed scenarios plus randomized ramps
// checked against a closed-form phase model.
module tb_qcw_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, fire, abort, clear_fault;
  logic [15:0] ramp_cycles, phase_step;
  logic [7:0]  phase_start, phase_end;
  logic [23:0] holdoff;
  logic        pll_cycle_finished, pll_done, pll_fault;
  logic        pll_start, pll_halt, busy, burst_done, fault_flag;
  logic [7:0]  phase_shift;
  logic [15:0] cycle_limit;
  logic [1:0]  fault_code;

  int compared   = 0;
  int mismatched = 0;
  int cur_ps, cur_pe, cur_st;
  logic fire_hold = 1'b0;

  always #5 clk = ~clk;

  qcw_ramp_ctrl #(.ARM_TIMEOUT(64), .WDOG_CYCLES(500)) dut (
    .clk(clk), .rst_n(rst_n), .fire(fire), .abort(abort), .clear_fault(clear_fault),
    .ramp_cycles(ramp_cycles), .phase_start(phase_start), .phase_end(phase_end),
    .phase_step(phase_step), .holdoff(holdoff),
    .pll_cycle_finished(pll_cycle_finished), .pll_done(pll_done), .pll_fault(pll_fault),
    .pll_start(pll_start), .pll_halt(pll_halt), .phase_shift(phase_shift),
    .cycle_limit(cycle_limit), .busy(busy), .burst_done(burst_done),
    .fault_flag(fault_flag), .fault_code(fault_code)
  );

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=no_finish expected=finish");
    $fatal(1, "bench time limit reached");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Phase after k steps: start plus/minus k*step, clamped at the end value
  function automatic int model_phase(input int ps, input int pe, input int st, input int k);
    int a, g;
    a = ps * 256;
    g = pe * 256;
    if (pe >= ps) begin
      a = a + k * st;
      if (a > g) a = g;
    end else begin
      a = a - k * st;
      if (a < g) a = g;
    end
    return a / 256;
  endfunction

  task automatic start_burst(input int ps, input int pe, input int st, input int rc, input int ho);
    phase_start = 8'(ps); phase_end = 8'(pe); phase_step = 16'(st);
    ramp_cycles = 16'(rc); holdoff = 24'(ho);
    cur_ps = ps; cur_pe = pe; cur_st = st;
    fire = 1'b1;
    tick();
    check("start_pulse", pll_start, 1);
    check("start_phase", phase_shift, ps);
    check("cycle_limit", cycle_limit, rc);
    check("start_busy", busy, 1);
    fire = fire_hold;
    tick();
    check("start_one_cycle", pll_start, 0);
    tick();
  endtask

  task automatic pulses(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      pll_cycle_finished = 1'b1;
      tick();
      pll_cycle_finished = 1'b0;
      check("phase_not_yet", phase_shift, model_phase(cur_ps, cur_pe, cur_st, base + i));
      tick();
      check("phase_step", phase_shift, model_phase(cur_ps, cur_pe, cur_st, base + i + 1));
      tick();
      tick();
      check("no_restart", pll_start, 0);
    end
  endtask

  // Called on the cycle that shows burst_done; busy must last holdoff+1 cycles
  task automatic holdoff_check(input int ho);
    int n, extra;
    n = 1;
    extra = 0;
    for (int i = 0; i < 70000 && busy === 1'b1; i++) begin
      tick();
      if (busy === 1'b1) n++;
      if (burst_done === 1'b1) extra++;
    end
    check("holdoff_len", n, ho + 1);
    check("single_done", extra, 0);
  endtask

  task automatic finish_done(input int ho);
    pll_done = 1'b1;
    tick();
    check("burst_done", burst_done, 1);
    check("done_code", fault_code, 0);
    pll_done = 1'b0;
    holdoff_check(ho);
  endtask

  initial begin
    int n, ps, pe, st, np, ho, rc;
    rst_n = 1'b0; fire = 1'b0; abort = 1'b0; clear_fault = 1'b0;
    ramp_cycles = 16'd0; phase_start = 8'd0; phase_end = 8'd0; phase_step = 16'd0;
    holdoff = 24'd0; pll_cycle_finished = 1'b0; pll_done = 1'b0; pll_fault = 1'b0;
    tick(); tick();
    check("rst_start", pll_start, 0);
    check("rst_halt", pll_halt, 0);
    check("rst_phase", phase_shift, 0);
    check("rst_climit", cycle_limit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    check("rst_fflag", fault_flag, 0);
    check("rst_fcode", fault_code, 0);
    rst_n = 1'b1;
    tick();

    // Upward ramp 0 -> 128 in steps of 4, then held
    start_burst(0, 128, 16'h0400, 40, 5);
    pulses(40, 0);
    check("ramp_top", phase_shift, 128);
    finish_done(5);

    // Downward ramp 200 -> 190 in steps of 3, clamped
    start_burst(200, 190, 16'h0300, 12, 2);
    pulses(6, 0);
    check("ramp_floor", phase_shift, 190);
    finish_done(2);

    // Abort after five cycles: halt until the PLL faults, no fault reported
    start_burst(10, 90, 16'h0180, 100, 1000);
    pulses(5, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n = 1;
    for (int i = 0; i < 10 && pll_halt !== 1'b1; i++) begin
      tick();
      n++;
    end
    check("abort_halt_lat", n, 2);
    tick(); tick(); tick();
    check("halt_held", pll_halt, 1);
    pll_fault = 1'b1;
    tick();
    check("halt_release", pll_halt, 0);
    check("abort_done", burst_done, 1);
    check("abort_fflag", fault_flag, 0);
    check("abort_fcode", fault_code, 0);
    pll_fault = 1'b0;
    holdoff_check(1000);

    // PLL never clears done: arm timeout after 64 cycles
    pll_done = 1'b1;
    phase_start = 8'd50; phase_end = 8'd60; phase_step = 16'h0100; holdoff = 24'd0;
    fire = 1'b1;
    tick();
    check("arm_start", pll_start, 1);
    fire = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && fault_flag !== 1'b1; i++) begin
      tick();
      n++;
    end
    check("arm_timeout_len", n, 64);
    check("arm_fcode", fault_code, 2);
    check("arm_fphase", phase_shift, 0);
    check("arm_fhalt", pll_halt, 0);
    pll_done = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clear_fflag", fault_flag, 0);
    check("clear_fcode", fault_code, 0);
    check("clear_busy", busy, 0);

    // Fault and done together in RUN: fault wins, no burst_done
    start_burst(30, 200, 16'h0800, 50, 3);
    pulses(2, 0);
    pll_fault = 1'b1;
    pll_done  = 1'b1;
    tick();
    check("pf_fflag", fault_flag, 1);
    check("pf_fcode", fault_code, 1);
    check("pf_nodone", burst_done, 0);
    check("pf_phase", phase_shift, 0);
    pll_fault = 1'b0;
    pll_done  = 1'b0;
    tick();
    check("pf_stays", fault_flag, 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("pf_clear", fault_code, 0);

    // holdoff=0 with fire held: one HOLDOFF cycle, then a re-trigger
    fire_hold = 1'b1;
    start_burst(100, 100, 16'h0000, 7, 0);
    pulses(3, 0);
    finish_done(0);
    tick();
    check("retrigger", pll_start, 1);
    check("retrig_phase", phase_shift, 100);
    fire_hold = 1'b0;
    fire = 1'b0;
    tick(); tick();
    finish_done(0);

    // Watchdog: PLL never finishes
    start_burst(0, 255, 16'h0010, 1000, 3);
`ifdef QCW_RAMP_WDOG_EN
    n = 0;
    for (int i = 0; i < 600 && pll_halt !== 1'b1; i++) begin
      tick();
      n++;
    end
    check("wdog_len", n, 500);
    pll_fault = 1'b1;
    tick();
    check("wdog_fflag", fault_flag, 1);
    check("wdog_fcode", fault_code, 3);
    check("wdog_halt", pll_halt, 0);
    pll_fault = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("wdog_clear", fault_flag, 0);
`else
    repeat (600) tick();
    check("nowd_halt", pll_halt, 0);
    check("nowd_fflag", fault_flag, 0);
    check("nowd_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    pll_fault = 1'b1;
    tick();
    check("nowd_done", burst_done, 1);
    check("nowd_fcode", fault_code, 0);
    pll_fault = 1'b0;
    holdoff_check(3);
`endif

    // Randomized ramps against the closed-form model
    for (int r = 0; r < 8; r++) begin
      ps = int'($urandom_range(0, 255));
      pe = int'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 16'h0A00));
      np = int'($urandom_range(3, 20));
      ho = int'($urandom_range(0, 20));
      rc = int'($urandom_range(0, 16'hFFFF));
      start_burst(ps, pe, st, rc, ho);
      pulses(np, 0);
      finish_done(ho);
    end

    // Reset in mid-burst clears outputs without waiting for a clock
    start_burst(40, 120, 16'h0200, 77, 4);
    pulses(3, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_phase", phase_shift, 0);
    check("mid_rst_climit", cycle_limit, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
